// File: rtl/program_counter.sv
// ============================================================================
// program_counter : fetch-address generator with BOOT/RUN/HALTED sequencing,
//                   prioritised jr/jump/branch redirects and a flush pulse.
// Revision 1.0
// ============================================================================
`default_nettype none

module program_counter #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        halt,
  input  logic        branch_taken,
  input  logic [15:0] branch_imm,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        jr,
  input  logic [31:0] jr_addr,
  output logic [31:0] PC,
  output logic [31:0] PC_plus4,
  output logic        fetch_valid,
  output logic        flush,
  output logic [31:0] instr_count
);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic [31:0] count_q;
  logic        flush_q;

  logic [31:0] pc_plus4_w;
  logic [31:0] branch_tgt_w;
  logic [31:0] target_raw_w;
  logic [31:0] target_w;
  logic        redirect_w;
  logic        run_go_w;
  logic        accept_w;

  always_comb begin
    pc_plus4_w   = pc_q + 32'd4;
    branch_tgt_w = pc_plus4_w + {{14{branch_imm[15]}}, branch_imm, 2'b00};
    redirect_w   = jr | jump | branch_taken;
    if (jr) begin
      target_raw_w = jr_addr;
    end else if (jump) begin
      target_raw_w = jump_target;
    end else begin
      target_raw_w = branch_tgt_w;
    end
    target_w = {target_raw_w[31:2], 2'b00};
    // halt outranks any redirect; stall freezes everything including halt
    run_go_w = (state_q == RUN) && !stall;
    accept_w = run_go_w && !halt;
    pc_d     = pc_q;
    if (accept_w) begin
      pc_d = redirect_w ? target_w : pc_plus4_w;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      count_q <= 32'd0;
      flush_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      flush_q <= accept_w && redirect_w;
      if (accept_w) begin
        count_q <= count_q + 32'd1;
      end
      case (state_q)
        BOOT:    state_q <= RUN;
        RUN:     if (run_go_w && halt) state_q <= HALTED;
        HALTED:  state_q <= HALTED;
        default: state_q <= BOOT;
      endcase
    end
  end

  assign PC          = pc_q;
  assign PC_plus4    = pc_plus4_w;
  assign fetch_valid = (state_q == RUN) && !stall;
  assign flush       = flush_q;
  assign instr_count = count_q;

endmodule

`default_nettype wire

// File: tb/tb_program_counter.sv
// ============================================================================
// tb_program_counter : directed vector bench for program_counter.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_program_counter;

  logic        clk;
  logic        reset_n;
  logic        stall;
  logic        halt;
  logic        branch_taken;
  logic [15:0] branch_imm;
  logic        jump;
  logic [31:0] jump_target;
  logic        jr;
  logic [31:0] jr_addr;
  logic [31:0] PC;
  logic [31:0] PC_plus4;
  logic        fetch_valid;
  logic        flush;
  logic [31:0] instr_count;

  int total;
  int bad;

  program_counter dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .stall        (stall),
    .halt         (halt),
    .branch_taken (branch_taken),
    .branch_imm   (branch_imm),
    .jump         (jump),
    .jump_target  (jump_target),
    .jr           (jr),
    .jr_addr      (jr_addr),
    .PC           (PC),
    .PC_plus4     (PC_plus4),
    .fetch_valid  (fetch_valid),
    .flush        (flush),
    .instr_count  (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        halt;
    logic        br;
    logic [15:0] imm;
    logic        jump;
    logic [31:0] jt;
    logic        jr;
    logic [31:0] jra;
    logic        fv;
    logic [31:0] pc;
    logic        fl;
    logic [31:0] cnt;
  } vec_t;

  vec_t vt[18];

  function automatic vec_t mk(input logic s, input logic h, input logic b,
                              input logic [15:0] im, input logic j,
                              input logic [31:0] jt, input logic r,
                              input logic [31:0] ra, input logic fv,
                              input logic [31:0] pc, input logic fl,
                              input logic [31:0] cnt);
    vec_t v;
    v.stall = s; v.halt = h; v.br = b; v.imm = im; v.jump = j; v.jt = jt;
    v.jr = r; v.jra = ra; v.fv = fv; v.pc = pc; v.fl = fl; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    stall = 0; halt = 0; branch_taken = 0; branch_imm = 16'h0;
    jump = 0; jump_target = 32'h0; jr = 0; jr_addr = 32'h0;
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    stall = v.stall; halt = v.halt; branch_taken = v.br; branch_imm = v.imm;
    jump = v.jump; jump_target = v.jt; jr = v.jr; jr_addr = v.jra;
    #1;
    chk($sformatf("vec%0d fetch_valid", idx), {31'd0, fetch_valid}, {31'd0, v.fv});
    @(posedge clk);
    #1;
    chk($sformatf("vec%0d PC", idx), PC, v.pc);
    chk($sformatf("vec%0d PC_plus4", idx), PC_plus4, v.pc + 32'd4);
    chk($sformatf("vec%0d flush", idx), {31'd0, flush}, {31'd0, v.fl});
    chk($sformatf("vec%0d instr_count", idx), instr_count, v.cnt);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    //            stall halt br  imm       jump jt             jr  jra            fv  pc             fl  cnt
    vt[0]  = mk(0, 0, 0, 16'h0000, 0, 32'h0,         1, 32'h0000_0100, 1, 32'h0000_0100, 1, 4);
    vt[1]  = mk(0, 0, 1, 16'h0000, 1, 32'h0000_3000, 1, 32'h0000_2003, 1, 32'h0000_2000, 1, 5);
    vt[2]  = mk(0, 0, 0, 16'h0000, 0, 32'h0,         0, 32'h0,         1, 32'h0000_2004, 0, 6);
    vt[3]  = mk(0, 0, 0, 16'h0000, 0, 32'h0,         1, 32'h0000_0100, 1, 32'h0000_0100, 1, 7);
    vt[4]  = mk(0, 0, 1, 16'hFFFE, 0, 32'h0,         0, 32'h0,         1, 32'h0000_00FC, 1, 8);
    vt[5]  = mk(0, 0, 0, 16'h0000, 1, 32'hFFFF_FFFE, 0, 32'h0,         1, 32'hFFFF_FFFC, 1, 9);
    vt[6]  = mk(0, 0, 0, 16'h0000, 0, 32'h0,         0, 32'h0,         1, 32'h0000_0000, 0, 10);
    vt[7]  = mk(0, 0, 1, 16'hFFFC, 0, 32'h0,         0, 32'h0,         1, 32'hFFFF_FFF4, 1, 11);
    vt[8]  = mk(0, 0, 1, 16'h7FFF, 0, 32'h0,         0, 32'h0,         1, 32'h0001_FFF4, 1, 12);
    vt[9]  = mk(0, 0, 0, 16'h0000, 0, 32'h0,         1, 32'h0000_0040, 1, 32'h0000_0040, 1, 13);
    vt[10] = mk(1, 0, 0, 16'h0000, 1, 32'h0000_5000, 0, 32'h0,         0, 32'h0000_0040, 0, 13);
    vt[11] = mk(1, 0, 0, 16'h0000, 1, 32'h0000_5000, 0, 32'h0,         0, 32'h0000_0040, 0, 13);
    vt[12] = mk(1, 0, 0, 16'h0000, 1, 32'h0000_5000, 0, 32'h0,         0, 32'h0000_0040, 0, 13);
    vt[13] = mk(0, 0, 0, 16'h0000, 1, 32'h0000_5000, 0, 32'h0,         1, 32'h0000_5000, 1, 14);
    vt[14] = mk(1, 0, 0, 16'h0000, 0, 32'h0,         0, 32'h0,         0, 32'h0000_5000, 0, 14);
    vt[15] = mk(1, 1, 0, 16'h0000, 0, 32'h0,         0, 32'h0,         0, 32'h0000_5000, 0, 14);
    vt[16] = mk(0, 0, 0, 16'h0000, 0, 32'h0,         1, 32'h0000_0080, 1, 32'h0000_0080, 1, 15);
    vt[17] = mk(0, 1, 0, 16'h0000, 1, 32'h0000_3000, 0, 32'h0,         1, 32'h0000_0080, 0, 15);

    clear_inputs();
    reset_n = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset PC", PC, 32'h0);
    chk("reset fetch_valid", {31'd0, fetch_valid}, 32'd0);
    chk("reset flush", {31'd0, flush}, 32'd0);
    chk("reset instr_count", instr_count, 32'd0);

    // BOOT cycle, then sequential fetch from RESET_PC
    @(negedge clk);
    reset_n = 1;
    #1;
    chk("boot fetch_valid", {31'd0, fetch_valid}, 32'd0);
    chk("boot PC", PC, 32'h0);
    @(posedge clk);
    #1;
    chk("run0 PC", PC, 32'h0);
    chk("run0 fetch_valid", {31'd0, fetch_valid}, 32'd1);
    chk("run0 instr_count", instr_count, 32'd0);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("seq%0d PC", k), PC, 32'(4 * k));
      chk($sformatf("seq%0d instr_count", k), instr_count, 32'(k));
    end

    for (int i = 0; i < 18; i++) apply(vt[i], i);

    // HALTED persists regardless of stall or redirects
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      halt = 0; jump = 0; jr = 1; jr_addr = 32'h0000_0900; stall = i[0];
      #1;
      chk($sformatf("halt%0d fetch_valid", i), {31'd0, fetch_valid}, 32'd0);
      @(posedge clk);
      #1;
      chk($sformatf("halt%0d PC", i), PC, 32'h0000_0080);
      chk($sformatf("halt%0d flush", i), {31'd0, flush}, 32'd0);
      chk($sformatf("halt%0d instr_count", i), instr_count, 32'd15);
    end

    // reset out of HALTED, asserted between edges
    #3;
    reset_n = 0;
    clear_inputs();
    #1;
    chk("halted-reset PC", PC, 32'h0);
    chk("halted-reset instr_count", instr_count, 32'd0);
    chk("halted-reset fetch_valid", {31'd0, fetch_valid}, 32'd0);

    @(negedge clk);
    reset_n = 1;
    @(posedge clk);
    #1;
    chk("reboot PC", PC, 32'h0);
    chk("reboot fetch_valid", {31'd0, fetch_valid}, 32'd1);
    @(negedge clk);
    jr = 1; jr_addr = 32'h0000_0044;
    @(posedge clk);
    #1;
    chk("pre-async PC", PC, 32'h0000_0044);
    chk("pre-async flush", {31'd0, flush}, 32'd1);
    #2;
    reset_n = 0;
    #1;
    chk("async PC", PC, 32'h0);
    chk("async flush", {31'd0, flush}, 32'd0);
    chk("async instr_count", instr_count, 32'd0);
    chk("async fetch_valid", {31'd0, fetch_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/program_counter.md
PROGRAM_COUNTER -- requirements
Module: program_counter

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the address loaded into PC on reset.
REQ-002 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 stall  input  1  SHALL be a hazard hold; when 1, PC is not updated.
REQ-005 halt  input  1  SHALL be a stop request from decode.
REQ-006 branch_taken  input  1  SHALL indicate a taken conditional branch.
REQ-007 branch_imm  input  16  SHALL be the raw branch immediate (word offset).
REQ-008 jump  input  1  SHALL indicate a j/jal instruction.
REQ-009 jump_target  input  32  SHALL be the concatenated jump address {PC_plus4[31:28], instr[25:0], 2'b00}.
REQ-010 jr  input  1  SHALL indicate a jump-register instruction.
REQ-011 jr_addr  input  32  SHALL be the register-sourced target.
REQ-012 PC  output  32  SHALL be the current fetch address.
REQ-013 PC_plus4  output  32  SHALL be combinational PC + 4, feeding the jump concatenation stage.
REQ-014 fetch_valid  output  1  SHALL mark that the fetch at PC is valid this cycle.
REQ-015 flush  output  1  SHALL be a one-cycle pulse after any accepted redirect.
REQ-016 instr_count  output  32  SHALL count accepted PC advances.

Function
REQ-017 States SHALL be BOOT, RUN, and HALTED.
REQ-018 BOOT SHALL last exactly one cycle after reset release, with fetch_valid = 0, PC = RESET_PC, and a transition to RUN.
REQ-019 In RUN, fetch_valid SHALL equal ~stall (combinational); in BOOT and HALTED, fetch_valid SHALL be 0.
REQ-020 In RUN with stall = 0 and halt = 0, next PC SHALL be chosen by priority: jr -> jr_addr; else jump -> jump_target; else branch_taken -> PC_plus4 + {sext(branch_imm), 2'b00}; else PC_plus4.
REQ-021 Every loaded redirect target SHALL have bits [1:0] forced to 2'b00.
REQ-022 All address arithmetic SHALL be modulo 2^32: PC 32'hFFFF_FFFC + 4 = 32'h0000_0000, and branch underflow wraps.
REQ-023 When stall = 1, PC, state, and instr_count SHALL hold; any concurrent jr/jump/branch_taken SHALL be ignored, and upstream SHALL hold it until stall drops.
REQ-024 An accepted redirect (jr, jump, or branch_taken with stall = 0 in RUN) SHALL set flush = 1 on the following cycle only.
REQ-025 Back-to-back accepted redirects SHALL produce flush = 1 on each following cycle.
REQ-026 halt = 1 in RUN with stall = 0 SHALL move the FSM to HALTED; PC SHALL hold, halt SHALL take priority over a simultaneous redirect, and flush SHALL not be asserted.
REQ-027 halt with stall = 1 SHALL be ignored.
REQ-028 HALTED SHALL be left only by reset.
REQ-029 instr_count SHALL increment by 1 on each RUN cycle with stall = 0 and halt = 0, and SHALL wrap 32'hFFFF_FFFF -> 0.
REQ-030 Fetch latency SHALL be one cycle: a selection made in cycle N SHALL appear on PC in cycle N+1.

Reset
REQ-031 While reset_n = 0, the block SHALL immediately hold PC = RESET_PC, state = BOOT, fetch_valid = 0, flush = 0, and instr_count = 0, independent of clk.
REQ-032 Reset asserted mid-operation, including in HALTED or during a flush pulse, SHALL abort the operation and apply REQ-031 in the same cycle.
REQ-033 Reset release SHALL be followed by the BOOT cycle.

Verification
REQ-034 Sequential fetch: reset, release, 4 free cycles -> PC = 0, 0 (BOOT), 4, 8, 0xC, and instr_count = 3.
REQ-035 Redirect priority: PC = 0x100 with jr = jump = branch_taken = 1, jr_addr = 0x2003, jump_target = 0x3000 -> next PC = 0x2000 and flush = 1 for one cycle.
REQ-036 Branch: PC = 0x100, branch_imm = 16'hFFFE, branch_taken = 1 -> next PC = 0xFC; then PC = 0xFFFF_FFFC with no redirect -> next PC = 0.
REQ-037 Stall with redirect: PC = 0x40, stall = 1 with jump = 1 for 3 cycles -> PC stays 0x40, flush = 0, fetch_valid = 0, instr_count unchanged; releasing stall -> PC = jump_target.
REQ-038 Halt: PC = 0x80 with halt = 1 and jump = 1 -> PC holds 0x80, state HALTED, fetch_valid = 0, and it persists 10 cycles until reset.
REQ-039 Asynchronous reset: assert reset_n = 0 between clock edges while PC = 0x44 and flush = 1 -> PC = RESET_PC and flush = 0 before the next edge.
